// File: rtl/uart_frame_streamer.sv
// Streams frames of buffered words to a byte-wide UART transmitter, one byte per tx_en/tx_done handshake.
// Each word is fetched from a synchronous-read buffer, split into bytes, and frames are separated by an idle gap.
module uart_frame_streamer #(
    parameter int WORD_W     = 24,
    parameter int DEPTH      = 64,
    parameter int FRAME_LEN  = 60,
    parameter int GAP_CYCLES = 16,
    parameter int MSB_FIRST  = 0,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    input  logic [7:0]        n_frames,
    input  logic              loop_mode,
    input  logic              abort,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_done,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frames_sent
);

    localparam int BPW      = WORD_W / 8;
    localparam int BIW      = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int FLW      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT, GAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic [BIW-1:0]     byte_idx_q, byte_idx_d;
    logic [FLW-1:0]     word_cnt_q, word_cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic               fetch_ph_q, fetch_ph_d;
    logic               abort_pend_q, abort_pend_d;
    logic [7:0]         n_frames_q, n_frames_d;
    logic               loop_q, loop_d;
    logic [7:0]         frames_sent_q, frames_sent_d;
    logic               frame_done_q, frame_done_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               wr_err_q, wr_err_d;
    logic               rd_en;
    logic [BIW-1:0]     byte_nxt;
    logic [7:0]         fs_inc;

    logic [WORD_W-1:0]  mem [DEPTH];
    logic [WORD_W-1:0]  mem_rd_q;

    function automatic logic [7:0] pick_byte(input logic [WORD_W-1:0] w, input logic [BIW-1:0] idx);
        int k;
        k = (MSB_FIRST != 0) ? (BPW - 1 - int'(idx)) : int'(idx);
        return w[8*k +: 8];
    endfunction

    assign busy        = (state_q != IDLE);
    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_sent_q;
    assign wr_err      = wr_err_q;
    assign byte_nxt    = byte_idx_q + BIW'(1);
    assign fs_inc      = (frames_sent_q == 8'hFF) ? 8'hFF : frames_sent_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        byte_idx_d    = byte_idx_q;
        word_cnt_d    = word_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        fetch_ph_d    = fetch_ph_q;
        abort_pend_d  = abort_pend_q;
        n_frames_d    = n_frames_q;
        loop_d        = loop_q;
        frames_sent_d = frames_sent_q;
        tx_data_d     = tx_data_q;
        frame_done_d  = 1'b0;
        tx_en_d       = 1'b0;
        wr_err_d      = wr_en && busy;
        rd_en         = 1'b0;

        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                fetch_ph_d   = 1'b0;
                if (start && (n_frames != 8'd0 || loop_mode)) begin
                    n_frames_d    = n_frames;
                    loop_d        = loop_mode;
                    rd_addr_d     = '0;
                    frames_sent_d = 8'd0;
                    byte_idx_d    = '0;
                    word_cnt_d    = '0;
                    state_d       = FETCH;
                end
            end
            // Phase 0 issues the read; phase 1 sees the word and launches its first byte.
            FETCH: begin
                if (abort) begin
                    state_d = DONE;
                end else if (!fetch_ph_q) begin
                    rd_en      = 1'b1;
                    rd_addr_d  = rd_addr_q + AW'(1);
                    fetch_ph_d = 1'b1;
                end else begin
                    fetch_ph_d = 1'b0;
                    byte_idx_d = '0;
                    tx_data_d  = pick_byte(mem_rd_q, '0);
                    tx_en_d    = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                state_d = abort ? DONE : WAIT;
            end
            WAIT: begin
                abort_pend_d = abort_pend_q || abort;
                if (tx_done) begin
                    if (abort_pend_q || abort) begin
                        state_d = DONE;
                    end else if (byte_idx_q != BIW'(BPW - 1)) begin
                        byte_idx_d = byte_nxt;
                        tx_data_d  = pick_byte(mem_rd_q, byte_nxt);
                        tx_en_d    = 1'b1;
                        state_d    = SEND;
                    end else if (word_cnt_q != FLW'(FRAME_LEN - 1)) begin
                        word_cnt_d = word_cnt_q + FLW'(1);
                        state_d    = FETCH;
                    end else begin
                        word_cnt_d    = '0;
                        gap_cnt_d     = '0;
                        frame_done_d  = 1'b1;
                        frames_sent_d = fs_inc;
                        if (loop_q || (fs_inc < n_frames_q))
                            state_d = (GAP_CYCLES == 0) ? FETCH : GAP;
                        else
                            state_d = DONE;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = DONE;
                end else if (gap_cnt_q == GW'(GAP_LAST)) begin
                    gap_cnt_d = '0;
                    state_d   = FETCH;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            byte_idx_q    <= '0;
            word_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            fetch_ph_q    <= 1'b0;
            abort_pend_q  <= 1'b0;
            n_frames_q    <= 8'd0;
            loop_q        <= 1'b0;
            frames_sent_q <= 8'd0;
            frame_done_q  <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= 8'd0;
            wr_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            byte_idx_q    <= byte_idx_d;
            word_cnt_q    <= word_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            fetch_ph_q    <= fetch_ph_d;
            abort_pend_q  <= abort_pend_d;
            n_frames_q    <= n_frames_d;
            loop_q        <= loop_d;
            frames_sent_q <= frames_sent_d;
            frame_done_q  <= frame_done_d;
            tx_en_q       <= tx_en_d;
            tx_data_q     <= tx_data_d;
            wr_err_q      <= wr_err_d;
        end
    end

    // Buffer storage is deliberately outside the reset domain so a reset keeps loaded frames.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            mem_rd_q <= mem[rd_addr_q];
    end

endmodule

// File: tb/tb_uart_frame_streamer.sv
// Directed bench: four streamer instances with different parameters, an auto-responding UART model per instance.
module tb_uart_frame_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  wr_en, start, loop_mode, abort, tx_done_man, man_mode, tx_done;
    logic [3:0]  tx_done_auto = '0;
    logic [5:0]  wa_w [2];
    logic [23:0] wd_w [2];
    logic [1:0]  wa_s [2];
    logic [7:0]  wd_s [2];
    logic [7:0]  n_frames [4];
    logic [3:0]  wr_err, tx_en, busy, frame_done;
    logic [7:0]  tx_data [4];
    logic [7:0]  frames_sent [4];

    assign tx_done = (man_mode & tx_done_man) | (~man_mode & tx_done_auto);

    uart_frame_streamer #(.WORD_W(24), .DEPTH(64), .FRAME_LEN(2), .GAP_CYCLES(16), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_addr(wa_w[0]), .wr_data(wd_w[0]), .wr_err(wr_err[0]),
        .start(start[0]), .n_frames(n_frames[0]), .loop_mode(loop_mode[0]), .abort(abort[0]),
        .tx_data(tx_data[0]), .tx_en(tx_en[0]), .tx_done(tx_done[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .frames_sent(frames_sent[0]));

    uart_frame_streamer #(.WORD_W(24), .DEPTH(64), .FRAME_LEN(2), .GAP_CYCLES(16), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_addr(wa_w[1]), .wr_data(wd_w[1]), .wr_err(wr_err[1]),
        .start(start[1]), .n_frames(n_frames[1]), .loop_mode(loop_mode[1]), .abort(abort[1]),
        .tx_data(tx_data[1]), .tx_en(tx_en[1]), .tx_done(tx_done[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .frames_sent(frames_sent[1]));

    uart_frame_streamer #(.WORD_W(8), .DEPTH(4), .FRAME_LEN(3), .GAP_CYCLES(5), .MSB_FIRST(0)) dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_addr(wa_s[0]), .wr_data(wd_s[0]), .wr_err(wr_err[2]),
        .start(start[2]), .n_frames(n_frames[2]), .loop_mode(loop_mode[2]), .abort(abort[2]),
        .tx_data(tx_data[2]), .tx_en(tx_en[2]), .tx_done(tx_done[2]), .busy(busy[2]),
        .frame_done(frame_done[2]), .frames_sent(frames_sent[2]));

    uart_frame_streamer #(.WORD_W(8), .DEPTH(4), .FRAME_LEN(1), .GAP_CYCLES(0), .MSB_FIRST(0)) dut_d (
        .clk(clk), .rst(rst), .wr_en(wr_en[3]), .wr_addr(wa_s[1]), .wr_data(wd_s[1]), .wr_err(wr_err[3]),
        .start(start[3]), .n_frames(n_frames[3]), .loop_mode(loop_mode[3]), .abort(abort[3]),
        .tx_data(tx_data[3]), .tx_en(tx_en[3]), .tx_done(tx_done[3]), .busy(busy[3]),
        .frame_done(frame_done[3]), .frames_sent(frames_sent[3]));

    int         cyc = 0;
    int         n_tx [4], n_fd [4], n_werr [4], uart_cnt [4], last_fd [4], gap_meas [4], hold_viol [4];
    bit         fd_pend [4];
    logic [7:0] tx_log [4][16];
    logic [7:0] last_byte [4];
    int         n_checks = 0;
    int         n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model answers each tx_en with tx_done three cycles later; also logs bytes, frames and gaps.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            tx_done_auto[i] = 1'b0;
            if (rst) uart_cnt[i] = 0;
            if (uart_cnt[i] > 0) begin
                if (!tx_en[i] && tx_data[i] !== last_byte[i]) hold_viol[i]++;
                uart_cnt[i]--;
                if (uart_cnt[i] == 0) tx_done_auto[i] = 1'b1;
            end
            if (frame_done[i]) begin
                n_fd[i]++;
                last_fd[i] = cyc;
                fd_pend[i] = 1'b1;
            end
            if (wr_err[i]) n_werr[i]++;
            if (tx_en[i]) begin
                if (n_tx[i] < 16) tx_log[i][n_tx[i]] = tx_data[i];
                n_tx[i]++;
                last_byte[i] = tx_data[i];
                uart_cnt[i]  = 3;
                if (fd_pend[i]) begin
                    gap_meas[i] = cyc - last_fd[i];
                    fd_pend[i]  = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_word(input int i, input int addr, input logic [23:0] d);
        @(negedge clk);
        wr_en[i] = 1'b1;
        if (i < 2) begin
            wa_w[i] = 6'(addr);
            wd_w[i] = d;
        end else begin
            wa_s[i-2] = 2'(addr);
            wd_s[i-2] = d[7:0];
        end
        @(negedge clk);
        wr_en[i] = 1'b0;
    endtask

    task automatic start_run(input int i, input logic [7:0] n, input logic lp);
        @(negedge clk);
        start[i]     = 1'b1;
        n_frames[i]  = n;
        loop_mode[i] = lp;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int maxc, input string tag);
        int c = 0;
        while (busy[i] && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'd0, busy[i]}, 32'd0);
    endtask

    task automatic wait_tx(input int i, input string tag);
        int c = 0;
        while (!tx_en[i] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'd0, tx_en[i]}, 32'd1);
    endtask

    logic [7:0] exp_a [6] = '{8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44};
    logic [7:0] exp_b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] exp_c [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
    logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    initial begin
        int t;
        int c;
        rst = 1'b1;
        wr_en = '0; start = '0; loop_mode = '0; abort = '0; tx_done_man = '0; man_mode = '0;
        for (int i = 0; i < 2; i++) begin
            wa_w[i] = '0; wd_w[i] = '0; wa_s[i] = '0; wd_s[i] = '0;
        end
        for (int i = 0; i < 4; i++) n_frames[i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx_en", {31'd0, tx_en[0]}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data[0]}, 32'd0);
        chk("rst_busy", {28'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done[0]}, 32'd0);
        chk("rst_wr_err", {31'd0, wr_err[0]}, 32'd0);
        chk("rst_frames_sent", {24'd0, frames_sent[0]}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            wr_word(i, 0, 24'h112233);
            wr_word(i, 1, 24'h445566);
        end
        for (int a = 0; a < 4; a++) begin
            wr_word(2, a, 24'(8'hA0 + a));
            wr_word(3, a, 24'(8'h10 + a));
        end
        chk("idle_write_no_err", 32'(n_werr[0]), 32'd0);

        // LSB-first frame, with a rejected overwrite of word 1 while streaming.
        start_run(0, 8'd1, 1'b0);
        wr_en[0] = 1'b1; wa_w[0] = 6'd1; wd_w[0] = 24'hABCDEF;
        @(negedge clk);
        wr_en[0] = 1'b0;
        chk("wr_err_pulse", {31'd0, wr_err[0]}, 32'd1);
        @(negedge clk);
        chk("wr_err_single", {31'd0, wr_err[0]}, 32'd0);
        wait_idle(0, 200, "a_timeout");
        chk("a_ntx", 32'(n_tx[0]), 32'd6);
        for (int k = 0; k < 6; k++) chk($sformatf("a_byte%0d", k), {24'd0, tx_log[0][k]}, {24'd0, exp_a[k]});
        chk("a_frame_done", 32'(n_fd[0]), 32'd1);
        chk("a_frames_sent", {24'd0, frames_sent[0]}, 32'd1);
        chk("a_wr_err_count", 32'(n_werr[0]), 32'd1);

        // MSB-first frame.
        start_run(1, 8'd1, 1'b0);
        wait_idle(1, 200, "b_timeout");
        chk("b_ntx", 32'(n_tx[1]), 32'd6);
        for (int k = 0; k < 6; k++) chk($sformatf("b_byte%0d", k), {24'd0, tx_log[1][k]}, {24'd0, exp_b[k]});
        chk("b_frame_done", 32'(n_fd[1]), 32'd1);

        // Two frames across a 4-deep buffer; frame_done shares the first GAP cycle, fetch adds two.
        start_run(2, 8'd2, 1'b0);
        wait_idle(2, 400, "c_timeout");
        chk("c_ntx", 32'(n_tx[2]), 32'd6);
        for (int k = 0; k < 6; k++) chk($sformatf("c_byte%0d", k), {24'd0, tx_log[2][k]}, {24'd0, exp_c[k]});
        chk("c_frame_done", 32'(n_fd[2]), 32'd2);
        chk("c_frames_sent", {24'd0, frames_sent[2]}, 32'd2);
        chk("c_gap", 32'(gap_meas[2]), 32'd7);

        // Start with nothing to send is ignored.
        start_run(0, 8'd0, 1'b0);
        chk("zero_start_busy", {31'd0, busy[0]}, 32'd0);
        repeat (5) @(negedge clk);
        chk("zero_start_ntx", 32'(n_tx[0]), 32'd6);
        chk("zero_start_fs_kept", {24'd0, frames_sent[0]}, 32'd1);

        // Abort seen during WAIT of byte 2, released before tx_done.
        man_mode[0] = 1'b1;
        start_run(0, 8'd1, 1'b0);
        wait_tx(0, "ab_first_tx");
        chk("ab_byte1", {24'd0, tx_data[0]}, 32'h33);
        @(negedge clk); tx_done_man[0] = 1'b1;
        @(negedge clk); tx_done_man[0] = 1'b0;
        chk("ab_byte2_en", {31'd0, tx_en[0]}, 32'd1);
        chk("ab_byte2", {24'd0, tx_data[0]}, 32'h22);
        @(negedge clk); abort[0] = 1'b1;
        @(negedge clk); abort[0] = 1'b0; tx_done_man[0] = 1'b1;
        @(negedge clk); tx_done_man[0] = 1'b0;
        chk("ab_busy_done", {31'd0, busy[0]}, 32'd1);
        @(negedge clk);
        chk("ab_busy_low", {31'd0, busy[0]}, 32'd0);
        repeat (6) @(negedge clk);
        chk("ab_ntx", 32'(n_tx[0]), 32'd8);
        chk("ab_no_frame_done", 32'(n_fd[0]), 32'd1);
        chk("ab_frames_sent", {24'd0, frames_sent[0]}, 32'd0);

        // Abort and tx_done together in WAIT.
        man_mode[1] = 1'b1;
        start_run(1, 8'd1, 1'b0);
        wait_tx(1, "sim_first_tx");
        @(negedge clk); abort[1] = 1'b1; tx_done_man[1] = 1'b1;
        @(negedge clk); abort[1] = 1'b0; tx_done_man[1] = 1'b0;
        chk("sim_busy_done", {31'd0, busy[1]}, 32'd1);
        chk("sim_no_tx", {31'd0, tx_en[1]}, 32'd0);
        @(negedge clk);
        chk("sim_busy_low", {31'd0, busy[1]}, 32'd0);
        repeat (4) @(negedge clk);
        chk("sim_ntx", 32'(n_tx[1]), 32'd7);
        chk("sim_no_frame_done", 32'(n_fd[1]), 32'd1);
        man_mode = '0;

        // Endless loop: saturation past 255 frames.
        start_run(3, 8'd0, 1'b1);
        c = 0;
        while (n_fd[3] < 300 && c < 6000) begin
            @(negedge clk);
            c++;
        end
        chk("loop_300_frames", {31'd0, n_fd[3] >= 300}, 32'd1);
        chk("loop_saturated", {24'd0, frames_sent[3]}, 32'd255);
        chk("loop_busy", {31'd0, busy[3]}, 32'd1);
        for (int k = 0; k < 5; k++) chk($sformatf("d_byte%0d", k), {24'd0, tx_log[3][k]}, {24'd0, exp_d[k]});
        chk("d_gap", 32'(gap_meas[3]), 32'd2);
        t = n_tx[3];
        repeat (20) @(negedge clk);
        chk("loop_continues", {31'd0, n_tx[3] > t}, 32'd1);
        chk("loop_still_sat", {24'd0, frames_sent[3]}, 32'd255);
        for (int i = 0; i < 4; i++) chk($sformatf("hold_%0d", i), 32'(hold_viol[i]), 32'd0);

        // Reset in the middle of streaming.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy[3]}, 32'd0);
        chk("mid_rst_tx_en", {31'd0, tx_en[3]}, 32'd0);
        chk("mid_rst_fs", {24'd0, frames_sent[3]}, 32'd0);
        rst = 1'b0;
        t = n_tx[3];
        repeat (20) @(negedge clk);
        chk("mid_rst_quiet", 32'(n_tx[3]), 32'(t));
        chk("mid_rst_idle", {31'd0, busy[3]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
